// File: rtl/vga_pkg.sv
// Shared types and colour constants for the VGA timing / test-pattern path.
package vga_pkg;

  typedef enum logic [1:0] {
    PAT_GRID  = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_mode_t;

  typedef logic [23:0] rgb_t;

  localparam rgb_t WHITE = 24'hFFFFFF;
  localparam rgb_t BLACK = 24'h000000;

  // Index 0 is the left-most bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_COLOURS = {
    24'h000000,  // 7 black
    24'h0000FF,  // 6 blue
    24'hFF0000,  // 5 red
    24'hFF00FF,  // 4 magenta
    24'h00FF00,  // 3 green
    24'h00FFFF,  // 2 cyan
    24'hFFFF00,  // 1 yellow
    24'hFFFFFF   // 0 white
  };

endpackage

// File: rtl/video_if.sv
// Parallel video bus: pixel clock, syncs, active-video flag and 24-bit colour.
interface video_if;
  logic        CLK;
  logic        HS;
  logic        VS;
  logic        BLANK;  // 1 = active video
  logic [23:0] RGB;

  modport master (output CLK, output HS, output VS, output BLANK, output RGB);
  modport slave  (input  CLK, input  HS, input  VS, input  BLANK, input  RGB);
endinterface

// File: rtl/vga_timing.sv
// Raster counters plus combinational decode of sync, active-video window,
// active-pixel coordinates and line/frame markers. All outputs are decoded
// from the current counter state; the parent registers them.
module vga_timing #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 12,
  parameter int VPULSE = 3,
  parameter int VBP    = 40,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  output logic                       o_hs,
  output logic                       o_vs,
  output logic                       o_blank,
  output logic                       o_line_start,
  output logic                       o_frame_start,
  output logic [$clog2(HDISP)-1:0]   o_x,
  output logic [$clog2(VDISP)-1:0]   o_y
);

  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int HBLANK = HTOTAL - HDISP;
  localparam int VBLANK = VTOTAL - VDISP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int XW     = $clog2(HDISP);
  localparam int YW     = $clog2(VDISP);

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;

  logic w_hwrap;
  logic w_vwrap;
  logic w_hact;
  logic w_vact;
  logic w_hs_on;
  logic w_vs_on;

  assign w_hwrap = (r_hcnt == HW'(HTOTAL - 1));
  assign w_vwrap = (r_vcnt == VW'(VTOTAL - 1));

  // Pixel counter wraps every line; line counter advances on each pixel wrap.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_hwrap) begin
      r_hcnt <= '0;
      r_vcnt <= w_vwrap ? '0 : r_vcnt + 1'b1;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  // Each line/frame runs front porch, sync, back porch, then active region.
  always_comb begin
    w_hs_on = (r_hcnt >= HW'(HFP)) && (r_hcnt < HW'(HFP + HPULSE));
    w_vs_on = (r_vcnt >= VW'(VFP)) && (r_vcnt < VW'(VFP + VPULSE));
    w_hact  = (r_hcnt >= HW'(HBLANK));
    w_vact  = (r_vcnt >= VW'(VBLANK));
  end

  // Polarised syncs, active flag, markers and zero-held coordinates.
  always_comb begin
    o_hs          = w_hs_on ? HS_POL : ~HS_POL;
    o_vs          = w_vs_on ? VS_POL : ~VS_POL;
    o_blank       = w_hact && w_vact;
    o_line_start  = (r_hcnt == '0);
    o_frame_start = (r_hcnt == '0) && (r_vcnt == '0);
    o_x           = '0;
    o_y           = '0;
    if (w_hact && w_vact) begin
      o_x = XW'(r_hcnt - HW'(HBLANK));
      o_y = YW'(r_vcnt - VW'(VBLANK));
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator. Pattern mode and solid colour are
// shadowed at raster position (0,0) so a frame is never torn by a mode change.
// Every output is registered one clock after the counter state that made it.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 12,
  parameter int VPULSE = 3,
  parameter int VBP    = 40,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int GRID   = 16
) (
  input  logic                      pixel_clk,
  input  logic                      pixel_rst,
  input  logic [1:0]                mode,
  input  logic [23:0]               solid_rgb,
  video_if.master                   video_ifm,
  output logic                      frame_start,
  output logic                      line_start,
  output logic [$clog2(HDISP)-1:0]  pix_x,
  output logic [$clog2(VDISP)-1:0]  pix_y,
  output logic [15:0]               frame_cnt
);

  localparam int XW   = $clog2(HDISP);
  localparam int YW   = $clog2(VDISP);
  localparam int BARW = HDISP / 8;
  localparam int GSH  = $clog2(GRID);

  if (GRID < 2 || (GRID & (GRID - 1)) != 0) begin : g_bad_grid
    $error("vga_pattern_gen: GRID must be a power of two >= 2");
  end
  if (HDISP < 8) begin : g_bad_hdisp
    $error("vga_pattern_gen: HDISP must be at least 8");
  end

  logic          w_hs;
  logic          w_vs;
  logic          w_blank;
  logic          w_line_start;
  logic          w_frame_start;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic [2:0]    w_bar;
  rgb_t          w_rgb;

  pattern_mode_t r_mode_q;
  rgb_t          r_solid_q;
  logic          r_seen_frame;
  logic [15:0]   r_frame_cnt;
  logic          r_hs;
  logic          r_vs;
  logic          r_blank;
  rgb_t          r_rgb;
  logic          r_line_start;
  logic          r_frame_start;
  logic [XW-1:0] r_pix_x;
  logic [YW-1:0] r_pix_y;

  vga_timing #(
    .HDISP (HDISP),  .VDISP (VDISP),
    .HFP   (HFP),    .HPULSE(HPULSE), .HBP(HBP),
    .VFP   (VFP),    .VPULSE(VPULSE), .VBP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .i_clk        (pixel_clk),
    .i_rst_n      (pixel_rst),
    .o_hs         (w_hs),
    .o_vs         (w_vs),
    .o_blank      (w_blank),
    .o_line_start (w_line_start),
    .o_frame_start(w_frame_start),
    .o_x          (w_x),
    .o_y          (w_y)
  );

  // Shadow the pattern controls once per frame, at raster position (0,0).
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst) begin
      r_mode_q  <= PAT_GRID;
      r_solid_q <= BLACK;
    end else if (w_frame_start) begin
      r_mode_q  <= pattern_mode_t'(mode);
      r_solid_q <= solid_rgb;
    end
  end

  // Colour-bar index by compare chain; anything past the last bar edge stays on bar 7.
  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (32'(w_x) >= 32'(k * BARW)) w_bar = 3'(k);
    end
  end

  // Pattern mux; black outside the active window.
  always_comb begin
    w_rgb = BLACK;
    if (w_blank) begin
      unique case (r_mode_q)
        PAT_GRID:  w_rgb = (((32'(w_x) & 32'(GRID - 1)) == 32'd0) ||
                            ((32'(w_y) & 32'(GRID - 1)) == 32'd0)) ? WHITE : BLACK;
        PAT_BARS:  w_rgb = BAR_COLOURS[w_bar];
        PAT_CHECK: w_rgb = ((((32'(w_x) >> GSH) ^ (32'(w_y) >> GSH)) & 32'd1) == 32'd0)
                           ? WHITE : BLACK;
        PAT_SOLID: w_rgb = r_solid_q;
        default:   w_rgb = BLACK;
      endcase
    end
  end

  // Count completed frames: the first frame start after reset opens frame 0.
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst) begin
      r_seen_frame <= 1'b0;
      r_frame_cnt  <= '0;
    end else if (w_frame_start) begin
      r_seen_frame <= 1'b1;
      if (r_seen_frame) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // Single output stage keeps syncs, blank, colour, markers and coordinates aligned.
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst) begin
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_blank       <= 1'b0;
      r_rgb         <= BLACK;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
    end else begin
      r_hs          <= w_hs;
      r_vs          <= w_vs;
      r_blank       <= w_blank;
      r_rgb         <= w_rgb;
      r_line_start  <= w_line_start;
      r_frame_start <= w_frame_start;
      r_pix_x       <= w_x;
      r_pix_y       <= w_y;
    end
  end

  assign video_ifm.CLK   = pixel_clk;
  assign video_ifm.HS    = r_hs;
  assign video_ifm.VS    = r_vs;
  assign video_ifm.BLANK = r_blank;
  assign video_ifm.RGB   = r_rgb;
  assign frame_start     = r_frame_start;
  assign line_start      = r_line_start;
  assign pix_x           = r_pix_x;
  assign pix_y           = r_pix_y;
  assign frame_cnt       = r_frame_cnt;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: pixel-vector table, a raster monitor for
// sync/blank/coordinate timing, and hand sequences for mode switch and reset.
module tb_vga_pattern_gen;

  // DUT1: default horizontal timing, short frame so several frames fit the run.
  localparam int HT    = 928;
  localparam int HB    = 128;
  localparam int VT    = 10;
  localparam int VB    = 4;
  localparam int FRAME = HT * VT;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic        frame_start, line_start;
  logic [9:0]  pix_x;
  logic [2:0]  pix_y;
  logic [15:0] frame_cnt;

  logic        fs2, ls2;
  logic [9:0]  pix_x2;
  logic [1:0]  pix_y2;
  logic [15:0] frame_cnt2;

  video_if vif ();
  video_if vif2 ();

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_on = 1'b0;
  bit d2_done = 1'b0;

  always #5 pixel_clk = ~pixel_clk;

  vga_pattern_gen #(
    .VDISP(6), .VFP(1), .VPULSE(2), .VBP(1), .GRID(4)
  ) dut (
    .pixel_clk  (pixel_clk),
    .pixel_rst  (pixel_rst),
    .mode       (mode),
    .solid_rgb  (solid_rgb),
    .video_ifm  (vif),
    .frame_start(frame_start),
    .line_start (line_start),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_cnt  (frame_cnt)
  );

  // DUT2: 640x480-style horizontal timing with active-high syncs, tiny frame.
  vga_pattern_gen #(
    .HDISP(640), .VDISP(4), .HFP(16), .HPULSE(96), .HBP(48),
    .VFP(1), .VPULSE(2), .VBP(1), .HS_POL(1'b1), .VS_POL(1'b1), .GRID(16)
  ) dut2 (
    .pixel_clk  (pixel_clk),
    .pixel_rst  (pixel_rst),
    .mode       (mode),
    .solid_rgb  (solid_rgb),
    .video_ifm  (vif2),
    .frame_start(fs2),
    .line_start (ls2),
    .pix_x      (pix_x2),
    .pix_y      (pix_y2),
    .frame_cnt  (frame_cnt2)
  );

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic wait_fs(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (frame_start !== 1'b1 && n < 2 * FRAME);
    if (frame_start !== 1'b1) timeout(tag);
  endtask

  task automatic wait_pos(input int x, input int y, input string tag);
    int n = 0;
    while (!(vif.BLANK === 1'b1 && int'(pix_x) == x && int'(pix_y) == y) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    if (n >= 2 * FRAME) timeout(tag);
  endtask

  task automatic pix_chk(input int x, input int y, input logic [23:0] exp, input string tag);
    wait_pos(x, y, tag);
    chk(tag, 32'(vif.RGB), 32'(exp));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rgb"},   32'(vif.RGB),   32'h0);
    chk({tag, "_blank"}, 32'(vif.BLANK), 32'h0);
    chk({tag, "_hs"},    32'(vif.HS),    32'h1);
    chk({tag, "_vs"},    32'(vif.VS),    32'h1);
    chk({tag, "_fs"},    32'(frame_start), 32'h0);
    chk({tag, "_ls"},    32'(line_start),  32'h0);
    chk({tag, "_pix_x"}, 32'(pix_x),     32'h0);
    chk({tag, "_pix_y"}, 32'(pix_y),     32'h0);
    chk({tag, "_fcnt"},  32'(frame_cnt), 32'h0);
    chk({tag, "_hs2"},   32'(vif2.HS),   32'h0);
  endtask

  // Raster monitor for DUT1: resyncs on frame_start, then checks every line
  // and frame period, sync placement, blank window, coordinates and blank colour.
  int lcyc = 0, fcyc = 0, lidx = 0;
  int hs_first = -1, hs_cnt = 0, vs_first = -1, vs_cnt = 0;
  int err = 0, fs_seen = 0;
  bit synced = 1'b0;

  always begin
    bit eb;
    int ex, ey;
    tick();
    if (!mon_on) begin
      synced  = 1'b0;
      fs_seen = 0;
    end else begin
      if (line_start === 1'b1) begin
        if (synced) begin
          chk("line_period", 32'(lcyc), 32'(HT - 1));
          chk("hs_start",    32'(hs_first), 32'd40);
          chk("hs_width",    32'(hs_cnt), 32'd48);
        end
        lcyc = 0; hs_first = -1; hs_cnt = 0;
      end else begin
        lcyc++;
      end
      if (frame_start === 1'b1) begin
        chk("frame_cnt", 32'(frame_cnt), 32'(fs_seen));
        fs_seen++;
        if (synced) begin
          chk("frame_period", 32'(fcyc), 32'(FRAME - 1));
          chk("lines_per_frame", 32'(lidx), 32'(VT - 1));
          chk("vs_start_line", 32'(vs_first), 32'd1);
          chk("vs_lines", 32'(vs_cnt), 32'd2);
          chk("raster_errs", 32'(err), 32'd0);
        end
        synced = 1'b1; fcyc = 0; lidx = 0; vs_first = -1; vs_cnt = 0; err = 0;
      end else begin
        fcyc++;
        if (line_start === 1'b1) lidx++;
      end
      if (line_start === 1'b1 && vif.VS === 1'b0) begin
        if (vs_first < 0) vs_first = lidx;
        vs_cnt++;
      end
      if (vif.HS === 1'b0) begin
        if (hs_first < 0) hs_first = lcyc;
        hs_cnt++;
      end
      if (synced) begin
        eb = (lcyc >= HB) && (lidx >= VB);
        ex = eb ? lcyc - HB : 0;
        ey = eb ? lidx - VB : 0;
        if (vif.BLANK !== eb || int'(pix_x) != ex || int'(pix_y) != ey) err++;
        if (!eb && vif.RGB !== 24'h0) err++;
      end
    end
  end

  // DUT2 measurement: one full frame from a frame_start.
  task automatic run_d2();
    int n = 0, c = 0, h_first = -1, h_cnt = 0, lper = -1, v_first = -1, v_cnt = 0, li = 0;
    while (fs2 !== 1'b1 && n < 8000) begin
      tick();
      n++;
    end
    if (fs2 !== 1'b1) timeout("d2_frame_start");
    do begin
      if (c < 800 && vif2.HS === 1'b1) begin
        if (h_first < 0) h_first = c;
        h_cnt++;
      end
      if (ls2 === 1'b1) begin
        if (c > 0) li++;
        if (c > 0 && lper < 0) lper = c;
        if (vif2.VS === 1'b1) begin
          if (v_first < 0) v_first = li;
          v_cnt++;
        end
      end
      tick();
      c++;
    end while (fs2 !== 1'b1 && c < 8000);
    chk("d2_hs_start",     32'(h_first), 32'd16);
    chk("d2_hs_high",      32'(h_cnt),   32'd96);
    chk("d2_line_period",  32'(lper),    32'd800);
    chk("d2_frame_period", 32'(c),       32'(800 * 8));
    chk("d2_vs_start",     32'(v_first), 32'd1);
    chk("d2_vs_lines",     32'(v_cnt),   32'd2);
    d2_done = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  mode;
    int          x;
    int          y;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [1:0] cur;
    vecs.push_back('{2'd2,   0, 0, 24'hFFFFFF});
    vecs.push_back('{2'd2,   3, 0, 24'hFFFFFF});
    vecs.push_back('{2'd2,   4, 0, 24'h000000});
    vecs.push_back('{2'd2,   8, 0, 24'hFFFFFF});
    vecs.push_back('{2'd2,   0, 4, 24'h000000});
    vecs.push_back('{2'd2,   4, 4, 24'hFFFFFF});
    vecs.push_back('{2'd2,   5, 5, 24'hFFFFFF});
    vecs.push_back('{2'd2,   9, 5, 24'h000000});
    vecs.push_back('{2'd1,   0, 0, 24'hFFFFFF});
    vecs.push_back('{2'd1,  99, 0, 24'hFFFFFF});
    vecs.push_back('{2'd1, 100, 0, 24'hFFFF00});
    vecs.push_back('{2'd1, 199, 1, 24'hFFFF00});
    vecs.push_back('{2'd1, 200, 1, 24'h00FFFF});
    vecs.push_back('{2'd1, 300, 2, 24'h00FF00});
    vecs.push_back('{2'd1, 400, 2, 24'hFF00FF});
    vecs.push_back('{2'd1, 500, 3, 24'hFF0000});
    vecs.push_back('{2'd1, 600, 3, 24'h0000FF});
    vecs.push_back('{2'd1, 700, 4, 24'h000000});
    vecs.push_back('{2'd1, 699, 5, 24'h0000FF});
    vecs.push_back('{2'd1, 799, 5, 24'h000000});
    vecs.push_back('{2'd0,   0, 0, 24'hFFFFFF});
    vecs.push_back('{2'd0,   5, 0, 24'hFFFFFF});
    vecs.push_back('{2'd0, 799, 0, 24'hFFFFFF});
    vecs.push_back('{2'd0,   0, 1, 24'hFFFFFF});
    vecs.push_back('{2'd0,   1, 1, 24'h000000});
    vecs.push_back('{2'd0,  15, 1, 24'h000000});
    vecs.push_back('{2'd0,  16, 1, 24'hFFFFFF});
    vecs.push_back('{2'd0,  32, 1, 24'hFFFFFF});

    pixel_rst = 1'b0;
    mode      = 2'd2;
    solid_rgb = 24'h0;
    cur       = 2'd2;
    repeat (3) tick();
    check_reset("rst0");

    pixel_rst = 1'b1;
    mon_on    = 1'b1;
    tick();
    chk("first_fs",   32'(frame_start), 32'h1);
    chk("first_ls",   32'(line_start),  32'h1);
    chk("first_fcnt", 32'(frame_cnt),   32'h0);

    fork
      run_d2();
    join_none

    foreach (vecs[i]) begin
      if (vecs[i].mode != cur) begin
        mode = vecs[i].mode;
        cur  = vecs[i].mode;
        wait_fs($sformatf("vec%0d_fs", i));
      end
      pix_chk(vecs[i].x, vecs[i].y, vecs[i].rgb, $sformatf("vec%0d_rgb", i));
    end

    // Grid -> solid switch mid-frame: rest of this frame stays grid.
    wait_pos(10, 2, "sw_pos");
    mode      = 2'd3;
    solid_rgb = 24'h123456;
    pix_chk(16, 3, 24'hFFFFFF, "sw_grid_16_3");
    pix_chk(17, 3, 24'h000000, "sw_grid_17_3");
    pix_chk(5, 4,  24'hFFFFFF, "sw_grid_5_4");
    pix_chk(6, 5,  24'h000000, "sw_grid_6_5");
    wait_fs("sw_fs");
    pix_chk(0, 0,   24'h123456, "solid_0_0");
    pix_chk(400, 3, 24'h123456, "solid_400_3");
    solid_rgb = 24'h654321;
    pix_chk(500, 5, 24'h123456, "solid_hold_500_5");
    pix_chk(799, 5, 24'h123456, "solid_hold_799_5");
    wait_fs("solid2_fs");
    pix_chk(0, 0, 24'h654321, "solid2_0_0");

    // One-cycle reset mid-frame.
    wait_pos(400, 3, "rst_pos");
    pixel_rst = 1'b0;
    mon_on    = 1'b0;
    mode      = 2'd1;
    tick();
    check_reset("rst_mid");
    pixel_rst = 1'b1;
    mon_on    = 1'b1;
    tick();
    chk("rel_fs",    32'(frame_start), 32'h1);
    chk("rel_ls",    32'(line_start),  32'h1);
    chk("rel_fcnt",  32'(frame_cnt),   32'h0);
    chk("rel_blank", 32'(vif.BLANK),   32'h0);
    pix_chk(99, 0,  24'hFFFFFF, "rel_bars_99");
    pix_chk(100, 0, 24'hFFFF00, "rel_bars_100");
    wait_fs("rel_next_fs");
    repeat (3) tick();

    for (int i = 0; i < 20000 && !d2_done; i++) tick();
    chk("d2_done", 32'(d2_done), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
